// File: rtl/receptor_paridade_impar_pkg.sv
// Shared definitions for the odd-parity serial receiver (and its future
// transmitter): FSM state encodings and the serial line levels.
package receptor_paridade_impar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } estado_t;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/receptor_paridade_impar_sincronizador_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// RST_VAL is the level both flops take in reset (idle level of the source).
module sincronizador_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next values: shift the raw input through the two stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops, reset to the line idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/receptor_paridade_impar.sv
// Odd-parity serial frame receiver.
// Frame: start(0), DATA_BITS data bits LSB first, parity, stop(1).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | line idle; wait for rx_s low (only once armed by a high level)
// ST_START  | wait to mid start bit and confirm it is still low
// ST_DATA   | sample one data bit every CLKS_PER_BIT cycles
// ST_PARITY | sample the parity bit
// ST_STOP   | sample the stop bit, publish result, back to IDLE at mid stop
module receptor_paridade_impar
    import receptor_paridade_impar_pkg::*;
#(
    parameter int DATA_BITS    = 3,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] HALF_TC  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_TC  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic rx_s;

    estado_t              state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    // Armed once the line has been seen high in IDLE; blocks a held-low
    // break after a bad stop bit from being taken as a new start.
    logic                 armed_q, armed_d;

    sincronizador_2ff #(.RST_VAL(IDLE_LVL)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // Next-state, sampling and result logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        armed_d = armed_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (rx_s == IDLE_LVL) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_TC) begin
                    cnt_d = '0;
                    bit_d = '0;
                    if (rx_s == START_LVL) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (cnt_q == FULL_TC) begin
                    cnt_d   = '0;
                    // LSB-first: each new bit enters at the top and moves down.
                    shift_d = shift_q >> 1;
                    shift_d[DATA_BITS-1] = rx_s;
                    if (bit_q == BIT_LAST) begin
                        bit_d   = '0;
                        state_d = ST_PARITY;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (cnt_q == FULL_TC) begin
                    cnt_d   = '0;
                    par_d   = rx_s;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt_q == FULL_TC) begin
                    cnt_d   = '0;
                    data_d  = shift_q;
                    perr_d  = ~(^{shift_q, par_q});
                    ferr_d  = ~rx_s;
                    valid_d = 1'b1;
                    armed_d = rx_s;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                bit_d   = '0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            armed_q <= armed_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_receptor_paridade_impar.sv
// Self-checking bench for the odd-parity serial receiver.
module tb_receptor_paridade_impar;

    localparam int N   = 3;
    localparam int C   = 16;
    localparam int LAT = 2 + C / 2 + (N + 2) * C;
    localparam int FRAME_CYCLES = (N + 3) * C;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rx = 1'b1;
    logic [N-1:0] data;
    logic         valid, parity_err, frame_err, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int           cyc;
        logic [N-1:0] d;
        logic         pe;
        logic         fe;
    } ev_t;

    ev_t mon_q[$];
    ev_t exp_q[$];

    receptor_paridade_impar #(.DATA_BITS(N), .CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Record every valid pulse with the outputs it qualifies.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            ev_t e;
            e.cyc = cyc; e.d = data; e.pe = parity_err; e.fe = frame_err;
            mon_q.push_back(e);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        tick(C);
    endtask

    // Drive a whole frame and queue the result the receiver should report.
    task automatic send_frame(input logic [N-1:0] d, input logic p, input logic stp,
                              output int start_cyc);
        ev_t e;
        start_cyc = cyc + 1;
        send_bit(1'b0);
        for (int i = 0; i < N; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(stp);
        e.cyc = start_cyc + LAT;
        e.d   = d;
        e.pe  = ($countones({d, p}) % 2) == 0;
        e.fe  = (stp == 1'b0);
        exp_q.push_back(e);
    endtask

    task automatic compare_results(input string tag);
        int n;
        chk({tag, ".count"}, mon_q.size(), exp_q.size());
        n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, ".cycle"}, mon_q[i].cyc, exp_q[i].cyc);
            chk({tag, ".data"},  32'(mon_q[i].d), 32'(exp_q[i].d));
            chk({tag, ".perr"},  32'(mon_q[i].pe), 32'(exp_q[i].pe));
            chk({tag, ".ferr"},  32'(mon_q[i].fe), 32'(exp_q[i].fe));
        end
        mon_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int s1, s2, g0;
        logic [N-1:0] rd;
        logic rp, rs;

        // Reset state
        #1;
        chk("rst.data", 32'(data), 0);
        chk("rst.valid", 32'(valid), 0);
        chk("rst.perr", 32'(parity_err), 0);
        chk("rst.ferr", 32'(frame_err), 0);
        chk("rst.busy", 32'(busy), 0);
        tick(3);
        rst_n = 1'b1;
        tick(5);

        // 1: all-zero data, correct parity
        send_frame(3'b000, 1'b1, 1'b1, s1);
        compare_results("t1");
        tick(C);
        chk("t1.busy_after", 32'(busy), 0);

        // 2: wrong then correct parity on 101
        send_frame(3'b101, 1'b0, 1'b1, s1);
        send_bit(1'b1);
        compare_results("t2a");
        send_frame(3'b101, 1'b1, 1'b1, s1);
        send_bit(1'b1);
        compare_results("t2b");

        // 3: bad stop bit, line then held low (break)
        send_frame(3'b111, 1'b0, 1'b0, s1);
        rx = 1'b0;
        tick(6 * C);
        compare_results("t3");
        chk("t3.busy_break", 32'(busy), 0);
        send_bit(1'b1);
        chk("t3.no_frame", mon_q.size(), 0);

        // 4: short low glitch is a false start
        g0 = cyc + 1;
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        while (cyc < g0 + 5) tick(1);
        chk("t4.busy_mid", 32'(busy), 1);
        while (cyc < g0 + 10) tick(1);
        chk("t4.busy_end", 32'(busy), 0);
        tick(6 * C);
        chk("t4.no_valid", mon_q.size(), 0);
        chk("t4.data_kept", 32'(data), 32'(3'b111));

        // 5: back-to-back frames
        send_frame(3'b011, 1'b1, 1'b1, s1);
        send_frame(3'b110, 1'b1, 1'b1, s2);
        send_bit(1'b1);
        if (mon_q.size() == 2)
            chk("t5.spacing", mon_q[1].cyc - mon_q[0].cyc, FRAME_CYCLES);
        else
            chk("t5.pulses", mon_q.size(), 2);
        compare_results("t5");

        // 6: reset during data bit 1
        send_bit(1'b0);
        send_bit(1'b1);
        rx = 1'b1;
        tick(C / 2);
        rst_n = 1'b0;
        #1;
        chk("t6.data", 32'(data), 0);
        chk("t6.valid", 32'(valid), 0);
        chk("t6.perr", 32'(parity_err), 0);
        chk("t6.ferr", 32'(frame_err), 0);
        chk("t6.busy", 32'(busy), 0);
        tick(3);
        rst_n = 1'b1;
        tick(20);
        chk("t6.no_valid", mon_q.size(), 0);
        send_frame(3'b010, 1'b0, 1'b1, s1);
        send_bit(1'b1);
        compare_results("t6");

        // Randomized frames against the reference model
        for (int k = 0; k < 20; k++) begin
            rd = N'($urandom);
            rp = 1'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            send_frame(rd, rp, rs, s1);
            if (!rs || $urandom_range(0, 1) == 1) send_bit(1'b1);
            compare_results("rand");
        end
        tick(2 * C);
        chk("final.busy", 32'(busy), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
